// File: rtl/axi_slave_ram_rw_if.sv
// AXI4 bus bundle for the slave RAM: AR/R read channels and AW/W/B write channels.
// The slave modport is used by axi_slave_ram_rw; the master modport by whatever drives it.
interface axi_slave_ram_rw_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
);
    localparam int NB = DATA_WIDTH / 8;

    // read address / read data
    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [7:0]               arlen;
    logic [2:0]               arsize;
    logic [1:0]               arburst;
    logic                     arvalid;
    logic                     arready;
    logic [DATA_WIDTH-1:0]    rdata;
    logic [1:0]               rresp;
    logic                     rlast;
    logic                     rvalid;
    logic                     rready;

    // write address / write data / write response
    logic [ADDRESS_WIDTH-1:0] awaddr;
    logic [7:0]               awlen;
    logic [2:0]               awsize;
    logic [1:0]               awburst;
    logic                     awvalid;
    logic                     awready;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [NB-1:0]            wstrb;
    logic                     wlast;
    logic                     wvalid;
    logic                     wready;
    logic [1:0]               bresp;
    logic                     bvalid;
    logic                     bready;

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid,
        input  awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid,
        output awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_slave_ram_rw.sv
// AXI4 slave RAM with independent read (AR/R) and write (AW/W/B) engines sharing one
// word array stored as byte lanes. FIXED and INCR bursts, byte strobes, SLVERR on
// illegal bursts and out-of-range beats.
// Optional feature: define AXI_RAM_WRAP_EN to support WRAP bursts (len+1 = 2/4/8/16);
// without it burst type 2 is treated as reserved.
module axi_slave_ram_rw #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 64
) (
    input  logic              aclk,
    input  logic              aresetn,
    axi_slave_ram_rw_if.slave axi
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int LOG_NB = $clog2(NB);
    localparam int MW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef AXI_RAM_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef logic [ADDRESS_WIDTH-1:0] addr_t;

    // Whole-burst legality: oversize beats, reserved type, or an unsupported wrap length.
    function automatic logic burst_bad(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        burst_bad = (int'(size) > LOG_NB) || (burst == 2'd3) ||
                    ((burst == 2'd2) && !(WRAP_EN && wrap_len_ok));
    endfunction

    function automatic logic out_of_range(input addr_t a);
        out_of_range = 32'(a >> LOG_NB) >= 32'(DEPTH);
    endfunction

    // Address of the following beat; low (sub-word) bits ride along untouched.
    function automatic addr_t next_addr(input addr_t a, input logic [1:0] burst,
                                        input logic [7:0] len);
        addr_t inc;
        addr_t mask;
        inc  = a + addr_t'(NB);
        mask = addr_t'(((32'(len) + 32'd1) << LOG_NB) - 32'd1);
        if (burst == 2'd0)
            next_addr = a;
        else if (burst == 2'd2)
            next_addr = (a & ~mask) | (inc & mask);
        else
            next_addr = inc;
    endfunction

    function automatic logic [MW-1:0] word_idx(input addr_t a);
        word_idx = a[LOG_NB +: MW];
    endfunction

    // ---------------- read engine signals ----------------
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    r_state_t              r_state_reg;
    addr_t                 r_addr_reg;
    logic [7:0]            r_len_reg;
    logic [7:0]            r_cnt_reg;
    logic [1:0]            r_burst_reg;
    logic                  r_bad_reg;
    addr_t                 r_load_addr;
    logic                  r_load_bad;
    logic                  r_beat_err;
    logic [DATA_WIDTH-1:0] r_word;

    // ---------------- write engine signals ----------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    w_state_t   w_state_reg;
    addr_t      w_addr_reg;
    logic [7:0] w_len_reg;
    logic [7:0] w_cnt_reg;
    logic [1:0] w_burst_reg;
    logic       w_bad_reg;
    logic       w_err_reg;
    logic       w_fire;
    logic       w_last_beat;
    logic       w_beat_err;
    logic       w_mismatch;
    logic       mem_we;

    // Address of the beat about to be loaded into rdata: the AR start address when idle,
    // otherwise the successor of the beat currently on the bus.
    always_comb begin
        if (r_state_reg == R_IDLE) begin
            r_load_addr = axi.araddr;
            r_load_bad  = burst_bad(axi.arsize, axi.arburst, axi.arlen);
        end else begin
            r_load_addr = next_addr(r_addr_reg, r_burst_reg, r_len_reg);
            r_load_bad  = r_bad_reg;
        end
    end

    assign r_beat_err  = r_load_bad || out_of_range(r_load_addr);

    assign w_fire      = (w_state_reg == W_DATA) && axi.wvalid;
    assign w_last_beat = (w_cnt_reg == w_len_reg);
    assign w_beat_err  = w_bad_reg || out_of_range(w_addr_reg);
    assign w_mismatch  = (axi.wlast != w_last_beat);
    assign mem_we      = w_fire && !w_beat_err;

    // Byte-lane storage: each lane is its own array so strobes map onto lane write enables.
    // Reads land in rdata on the clock edge, so a same-edge write is only seen by later beats.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            // Lane write, gated by this lane's strobe bit.
            always_ff @(posedge aclk) begin
                if (mem_we && axi.wstrb[gi])
                    lane_mem[word_idx(w_addr_reg)] <= axi.wdata[gi*8 +: 8];
            end

            assign r_word[gi*8 +: 8] = lane_mem[word_idx(r_load_addr)];
        end
    endgenerate

    // Read FSM: latch AR, present one beat at a time, advance on each R handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_reg <= R_IDLE;
            r_addr_reg  <= '0;
            r_len_reg   <= '0;
            r_cnt_reg   <= '0;
            r_burst_reg <= '0;
            r_bad_reg   <= 1'b0;
            axi.arready <= 1'b1;
            axi.rvalid  <= 1'b0;
            axi.rlast   <= 1'b0;
            axi.rdata   <= '0;
            axi.rresp   <= RESP_OKAY;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (axi.arvalid) begin
                        r_addr_reg  <= r_load_addr;
                        r_len_reg   <= axi.arlen;
                        r_burst_reg <= axi.arburst;
                        r_bad_reg   <= r_load_bad;
                        r_cnt_reg   <= 8'd0;
                        axi.rdata   <= r_beat_err ? '0 : r_word;
                        axi.rresp   <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
                        axi.rlast   <= (axi.arlen == 8'd0);
                        axi.rvalid  <= 1'b1;
                        axi.arready <= 1'b0;
                        r_state_reg <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (axi.rready) begin
                        if (r_cnt_reg == r_len_reg) begin
                            axi.rvalid  <= 1'b0;
                            axi.rlast   <= 1'b0;
                            axi.arready <= 1'b1;
                            r_state_reg <= R_IDLE;
                        end else begin
                            r_addr_reg <= r_load_addr;
                            r_cnt_reg  <= r_cnt_reg + 8'd1;
                            axi.rdata  <= r_beat_err ? '0 : r_word;
                            axi.rresp  <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
                            axi.rlast  <= ((r_cnt_reg + 8'd1) == r_len_reg);
                        end
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    // Write FSM: latch AW, count beats to awlen (wlast only checked), then hold B until bready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_reg <= W_IDLE;
            w_addr_reg  <= '0;
            w_len_reg   <= '0;
            w_cnt_reg   <= '0;
            w_burst_reg <= '0;
            w_bad_reg   <= 1'b0;
            w_err_reg   <= 1'b0;
            axi.awready <= 1'b1;
            axi.wready  <= 1'b0;
            axi.bvalid  <= 1'b0;
            axi.bresp   <= RESP_OKAY;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (axi.awvalid) begin
                        w_addr_reg  <= axi.awaddr;
                        w_len_reg   <= axi.awlen;
                        w_burst_reg <= axi.awburst;
                        w_bad_reg   <= burst_bad(axi.awsize, axi.awburst, axi.awlen);
                        w_cnt_reg   <= 8'd0;
                        w_err_reg   <= 1'b0;
                        axi.awready <= 1'b0;
                        axi.wready  <= 1'b1;
                        w_state_reg <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (axi.wvalid) begin
                        if (w_last_beat) begin
                            axi.wready  <= 1'b0;
                            axi.bvalid  <= 1'b1;
                            axi.bresp   <= (w_err_reg || w_beat_err || w_mismatch) ?
                                           RESP_SLVERR : RESP_OKAY;
                            w_state_reg <= W_RESP;
                        end else begin
                            w_addr_reg <= next_addr(w_addr_reg, w_burst_reg, w_len_reg);
                            w_cnt_reg  <= w_cnt_reg + 8'd1;
                            w_err_reg  <= w_err_reg || w_beat_err || w_mismatch;
                        end
                    end
                end
                W_RESP: begin
                    if (axi.bready) begin
                        axi.bvalid  <= 1'b0;
                        axi.awready <= 1'b1;
                        w_state_reg <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_slave_ram_rw.sv
// Bench for axi_slave_ram_rw: directed bursts from the test plan plus random bursts,
// all checked against a byte-level memory model with burst addresses computed arithmetically.
module tb_axi_slave_ram_rw;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int NB    = DW / 8;

`ifdef AXI_RAM_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    logic [DW-1:0] model_mem [DEPTH];

    axi_slave_ram_rw_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_slave_ram_rw #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .axi     (bus)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input int len, input int burst, input int size);
        if (size > $clog2(NB)) return 1'b0;
        if (burst == 0 || burst == 1) return 1'b1;
        if (burst == 2 && WRAP) return (len == 1 || len == 3 || len == 7 || len == 15);
        return 1'b0;
    endfunction

    // Byte address of beat k of a burst.
    function automatic int beat_addr(input int a, input int len, input int burst, input int k);
        int total, base;
        if (burst == 0) return a;
        if (burst == 2) begin
            total = (len + 1) * NB;
            base  = a - (a % total);
            return (base + ((a - base) + k * NB) % total) % (1 << AW);
        end
        return (a + k * NB) % (1 << AW);
    endfunction

    // dmode: 0 = d0*(k+1) with strobe s0, 1 = random data full strobe, 2 = random data and strobe.
    // early: beat index carrying an early wlast, -1 for none.
    task automatic do_write(input int a, input int len, input int burst, input int size,
                            input int dmode, input logic [DW-1:0] d0, input logic [NB-1:0] s0,
                            input int early);
        bit            exp_err;
        int            ba;
        logic [DW-1:0] d;
        logic [NB-1:0] s;
        logic          lst;
        exp_err = 1'b0;
        @(negedge aclk);
        check("awready_idle", 64'(bus.awready), 64'(1));
        bus.awaddr  = 8'(a);
        bus.awlen   = 8'(len);
        bus.awsize  = 3'(size);
        bus.awburst = 2'(burst);
        bus.awvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bus.awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            if (dmode != 0) begin
                while ($urandom_range(3) == 0) begin
                    bus.wvalid = 1'b0;
                    @(negedge aclk);
                end
            end
            d   = (dmode == 0) ? d0 * DW'(k + 1) : DW'($urandom);
            s   = (dmode == 0) ? s0 : ((dmode == 1) ? {NB{1'b1}} : NB'($urandom));
            lst = (k == len) || (k == early);
            check("wready", 64'(bus.wready), 64'(1));
            bus.wvalid = 1'b1;
            bus.wdata  = d;
            bus.wstrb  = s;
            bus.wlast  = lst;
            ba = beat_addr(a, len, burst, k);
            if (!legal(len, burst, size) || (ba / NB) >= DEPTH)
                exp_err = 1'b1;
            else
                for (int b = 0; b < NB; b++)
                    if (s[b]) model_mem[ba / NB][b*8 +: 8] = d[b*8 +: 8];
            if (lst != (k == len)) exp_err = 1'b1;
            @(posedge aclk);
            @(negedge aclk);
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        check("bvalid", 64'(bus.bvalid), 64'(1));
        check("bresp", 64'(bus.bresp), exp_err ? 64'(2) : 64'(0));
        repeat ($urandom_range(2)) begin
            @(negedge aclk);
            check("bvalid_hold", 64'(bus.bvalid), 64'(1));
        end
        bus.bready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bus.bready = 1'b0;
        check("bvalid_clear", 64'(bus.bvalid), 64'(0));
        check("awready_back", 64'(bus.awready), 64'(1));
        $display("write addr=%02h len=%0d burst=%0d size=%0d expected_bresp=%0d",
                 a, len, burst, size, exp_err ? 2 : 0);
    endtask

    // rmode: 0 = rready held high, 1 = rready toggles 0/1, 2 = random stalls.
    task automatic do_read(input int a, input int len, input int burst, input int size,
                           input int rmode);
        int            ba, nstall, nerr;
        bit            err;
        logic [DW-1:0] exp_d;
        nerr = 0;
        @(negedge aclk);
        check("arready_idle", 64'(bus.arready), 64'(1));
        bus.araddr  = 8'(a);
        bus.arlen   = 8'(len);
        bus.arsize  = 3'(size);
        bus.arburst = 2'(burst);
        bus.arvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bus.arvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            ba    = beat_addr(a, len, burst, k);
            err   = !legal(len, burst, size) || (ba / NB) >= DEPTH;
            exp_d = err ? '0 : model_mem[ba / NB];
            if (err) nerr++;
            nstall = (rmode == 1) ? 1 : ((rmode == 2) ? int'($urandom_range(2)) : 0);
            check("rvalid", 64'(bus.rvalid), 64'(1));
            for (int sc = 0; sc < nstall; sc++) begin
                bus.rready = 1'b0;
                @(negedge aclk);
                check("rdata_stall", 64'(bus.rdata), 64'(exp_d));
                check("rvalid_stall", 64'(bus.rvalid), 64'(1));
            end
            bus.rready = 1'b1;
            check("rdata", 64'(bus.rdata), 64'(exp_d));
            check("rresp", 64'(bus.rresp), err ? 64'(2) : 64'(0));
            check("rlast", 64'(bus.rlast), 64'(k == len));
            @(posedge aclk);
            @(negedge aclk);
        end
        bus.rready = 1'b0;
        check("rvalid_end", 64'(bus.rvalid), 64'(0));
        check("arready_back", 64'(bus.arready), 64'(1));
        $display("read  addr=%02h len=%0d burst=%0d size=%0d error_beats=%0d",
                 a, len, burst, size, nerr);
    endtask

    initial begin
        int a, len, burst, size, early;
        bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.wvalid = 1'b0; bus.bready = 1'b0;

        // reset state
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_arready", 64'(bus.arready), 64'(1));
        check("rst_awready", 64'(bus.awready), 64'(1));
        check("rst_rvalid",  64'(bus.rvalid),  64'(0));
        check("rst_rlast",   64'(bus.rlast),   64'(0));
        check("rst_wready",  64'(bus.wready),  64'(0));
        check("rst_bvalid",  64'(bus.bvalid),  64'(0));
        check("rst_rdata",   64'(bus.rdata),   64'(0));
        check("rst_rresp",   64'(bus.rresp),   64'(0));
        check("rst_bresp",   64'(bus.bresp),   64'(0));
        aresetn = 1'b1;

        // fill every word so later reads are fully defined
        do_write(0, DEPTH - 1, 1, 2, 1, '0, '0, -1);

        // basic INCR write then back-to-back read
        do_write(0, 3, 1, 2, 0, 32'h11, 4'hF, -1);
        do_read(0, 3, 1, 2, 0);

        // byte strobe merge
        do_write(8, 0, 1, 2, 0, 32'hAABBCCDD, 4'hF, -1);
        do_write(8, 0, 1, 2, 0, 32'h00000011, 4'h1, -1);
        do_read(8, 0, 1, 2, 0);

        // rready toggling, five beats
        do_read(4, 4, 1, 2, 1);

        // burst running off the end of the array
        do_write(DEPTH * NB - 4, 1, 1, 2, 0, 32'h5A5A0001, 4'hF, -1);
        do_read(DEPTH * NB - 4, 0, 1, 2, 0);
        do_read(DEPTH * NB - 4, 1, 1, 2, 0);

        // early wlast
        do_write(48, 3, 1, 2, 0, 32'h01010101, 4'hF, 1);
        do_read(48, 3, 1, 2, 2);

        // wrap burst (legal only with the wrap feature)
        do_read(8, 3, 2, 2, 0);
        do_write(0, 3, 2, 2, 0, 32'hDEAD0000, 4'hF, -1);
        do_read(0, 3, 1, 2, 0);

        // FIXED burst, oversize beat
        do_write(16, 2, 0, 2, 2, '0, '0, -1);
        do_read(16, 2, 0, 2, 2);
        do_write(20, 1, 1, 3, 0, 32'hFFFFFFFF, 4'hF, -1);
        do_read(20, 1, 1, 3, 0);
        do_read(20, 1, 1, 2, 0);

        // read and write engines at the same time on disjoint words
        fork
            do_write(80, 3, 1, 2, 2, '0, '0, -1);
            do_read(0, 7, 1, 2, 2);
        join

        // reset in the middle of a write burst: first beat lands, the rest is abandoned
        @(negedge aclk);
        bus.awaddr = 8'd40; bus.awlen = 8'd3; bus.awsize = 3'd2; bus.awburst = 2'd1;
        bus.awvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b1; bus.wdata = 32'hC0FFEE01; bus.wstrb = 4'hF; bus.wlast = 1'b0;
        model_mem[10] = 32'hC0FFEE01;
        @(posedge aclk);
        @(negedge aclk);
        bus.wvalid = 1'b0;
        aresetn = 1'b0;
        #1;
        check("midrst_awready", 64'(bus.awready), 64'(1));
        check("midrst_wready",  64'(bus.wready),  64'(0));
        check("midrst_bvalid",  64'(bus.bvalid),  64'(0));
        $display("reset asserted mid write burst at addr=28");
        @(negedge aclk);
        aresetn = 1'b1;
        do_read(40, 0, 1, 2, 0);

        // random bursts
        for (int i = 0; i < 24; i++) begin
            a     = int'($urandom_range(255));
            len   = int'($urandom_range(7));
            burst = int'($urandom_range(3));
            size  = ($urandom_range(3) == 0) ? int'($urandom_range(7)) : 2;
            early = ($urandom_range(4) == 0) ? int'($urandom_range(len)) : -1;
            if (i % 2 == 0)
                do_write(a, len, burst, size, 2, '0, '0, early);
            else
                do_read(a, len, burst, size, 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_slave_ram_rw.md
Name: axi_slave_ram_rw

Overview:
Parametrised AXI4 slave RAM. It serves both the read channels (AR/R) and the write channels (AW/W/B) from one shared word array, with independent read and write engines. Supports FIXED and INCR bursts, byte strobes, and SLVERR signalling for illegal or out-of-range accesses. Successor to the read-only slave RAM; sits on the demo interconnect as a bus-attached memory target.

Parameters:
ADDRESS_WIDTH, 8, byte address width of araddr/awaddr
DATA_WIDTH, 32, data bus width in bits (8/16/32/64); NB = DATA_WIDTH/8 bytes per beat
DEPTH, 64, number of DATA_WIDTH words in the array; valid byte range 0 .. DEPTH*NB-1

Ports:
aclk  in  1  clock; all state changes on rising edge
aresetn  in  1  reset, asynchronous, active-low
araddr  in  ADDRESS_WIDTH  read burst start byte address
arlen  in  8  read beats minus 1
arsize  in  3  log2 bytes per beat
arburst  in  2  0=FIXED 1=INCR 2=WRAP 3=reserved
arvalid  in  1  read address valid
arready  out  1  read address accept
rdata  out  DATA_WIDTH  read beat data
rresp  out  2  0=OKAY 2=SLVERR
rlast  out  1  final read beat
rvalid  out  1  read data valid
rready  in  1  master accepts read beat
awaddr  in  ADDRESS_WIDTH  write burst start byte address
awlen  in  8  write beats minus 1
awsize  in  3  log2 bytes per beat
awburst  in  2  burst type, encoding as arburst
awvalid  in  1  write address valid
awready  out  1  write address accept
wdata  in  DATA_WIDTH  write beat data
wstrb  in  NB  byte enables
wlast  in  1  master's last-beat marker
wvalid  in  1  write data valid
wready  out  1  write data accept
bresp  out  2  burst write response
bvalid  out  1  write response valid
bready  in  1  master accepts response

Behaviour:
- Reset (async assert, sync release): arready=1, awready=1; rvalid, rlast, wready, bvalid=0; rdata=0; rresp, bresp=0. RAM contents are not reset. Reset mid-burst abandons the burst; no response is issued.
- Word index = addr >> log2(NB). Addresses are treated as aligned (low bits ignored).
- Legality, checked per burst: size > log2(NB) or burst==3 (or burst==2 with feature off) makes every beat SLVERR. Per beat: word index >= DEPTH is SLVERR.
- Beat address stepping: FIXED keeps the same address; INCR adds NB per beat, wrapping modulo 2^ADDRESS_WIDTH.
- Read FSM R_IDLE/R_DATA:
  - R_IDLE: arready=1. On AR handshake, latch the burst, load beat 0 into rdata/rresp, assert rvalid next cycle, set arready=0.
  - R_DATA: rvalid held with data stable until rready. On R handshake, advance and load the next beat in the same edge, giving one beat per cycle when rready is held high.
  - rlast=1 exactly on beat arlen. Error beats drive rdata=0 and rresp=2.
  - After the last handshake, go to R_IDLE; arready=1 the next cycle.
- Write FSM W_IDLE/W_DATA/W_RESP:
  - W_IDLE: awready=1. On AW handshake, go to W_DATA (wready=1, awready=0).
  - W_DATA: each W handshake writes the bytes selected by wstrb at the current beat address, unless the beat is an error. The beat counter ends the burst at awlen, regardless of wlast.
  - A wlast mismatch (wlast=1 early, or wlast=0 on the final beat) sets a sticky error flag.
  - W_RESP: bvalid=1; bresp=2 if any beat error or mismatch occurred, else 0. Hold until bready; then go to W_IDLE.
- Read and write engines run concurrently. On a same-cycle write and read of the same word, the read beat gets the pre-write data; the write is visible to later beats.
- arlen=0 / awlen=0: single-beat burst with rlast on beat 0.

Optional Feature:
AXI_RAM_WRAP_EN
- Defined: burst==2 is supported. Legal only when len+1 is 2, 4, 8 or 16, otherwise SLVERR for the whole burst. Wrap boundary = (len+1)*NB aligned; the address steps as INCR and wraps to the boundary base.
- Undefined: burst==2 is treated as reserved (all beats SLVERR, no writes).

Test Plan:
- Reset, then AW addr=0 len=3 INCR with data 0x11..0x44, wstrb=F -> bvalid with bresp=0; then AR addr=0 len=3 with rready=1 -> rdata 0x11,0x22,0x33,0x44 on 4 consecutive cycles, rlast only on the 4th.
- Write 0xAABBCCDD to addr 8, then a single-beat write 0x00000011 with wstrb=0001 -> readback 0xAABBCC11.
- Read with arlen=4 and rready toggling 1/0 -> rdata stable while rready=0; exactly 5 beats delivered.
- awaddr=DEPTH*NB-4, awlen=1 INCR -> first beat written, second beat suppressed, bresp=2; read of word DEPTH-1 shows the first-beat data.
- Write with wlast asserted on beat 1 of awlen=3 -> 4 beats accepted, bresp=2.
- With AXI_RAM_WRAP_EN: AR addr=8 len=3 WRAP on DATA_WIDTH=32 -> word addresses 8,12,0,4; without the macro -> rresp=2 on all 4 beats.
